// File: rtl/chase_tp_scheduler_pkg.sv
// Shared definitions for the Chase-II test-pattern scheduler.
// Holds GF symbol width, bus widths, FSM state encoding, the code-select constant for
// the 8-syndrome (t=4) code, test-pattern index constants and the tp1 zero-detect helper.
package chase_tp_scheduler_pkg;

  localparam int unsigned W       = 10;        // GF symbol width
  localparam int unsigned NSYN    = 8;         // syndromes per set
  localparam int unsigned SYN_W   = NSYN * W;  // packed syndrome bus, S1 in [W-1:0]
  localparam int unsigned LO_W    = 4 * W;     // S1..S4 slice
  localparam int unsigned ALPHA_W = 4 * W;     // {a^7p, a^5p, a^3p, a^p}

  typedef logic [SYN_W-1:0]   synd_t;
  typedef logic [ALPHA_W-1:0] alpha_t;
  typedef logic [1:0]         tp_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StIssue
  } state_e;

  localparam logic [1:0] CODE_T4 = 2'b10;

  localparam tp_idx_t TP1 = 2'd0;
  localparam tp_idx_t TP2 = 2'd1;
  localparam tp_idx_t TP3 = 2'd2;
  localparam tp_idx_t TP4 = 2'd3;

  // tp1 counts as error-free when every syndrome the code actually uses is zero.
  function automatic logic tp1_is_zero(synd_t s, logic [1:0] code);
    if (code == CODE_T4) return s == '0;
    return s[LO_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/chase_tp_scheduler_if.sv
// Bus bundle between the scheduler and its environment (codeword source, flip_syndrome
// datapath, key-equation solver). i_* are driven into the scheduler, o_* are driven by it.
// Modports: slave = scheduler side, master = environment side.
interface chase_tp_scheduler_if;
  import chase_tp_scheduler_pkg::*;

  // Codeword intake
  logic [1:0] i_code;
  logic       i_start;
  logic       o_in_ready;
  synd_t      i_synd;
  alpha_t     i_alpha1;
  alpha_t     i_alpha2;
  logic       i_abort;
  // flip_syndrome datapath
  logic [1:0] o_fs_code;
  synd_t      o_fs_synd;
  alpha_t     o_fs_alpha1;
  alpha_t     o_fs_alpha2;
  logic       o_fs_valid;
  synd_t      i_fs_tp2;
  synd_t      i_fs_tp3;
  synd_t      i_fs_tp4;
  logic       i_fs_tp_valid;
  // Key-equation solver
  logic       o_tp_valid;
  logic       i_tp_ready;
  synd_t      o_tp_synd;
  tp_idx_t    o_tp_idx;
  logic       o_tp_last;
  logic       o_done;
  logic       o_err;

  modport slave (
    input  i_code, i_start, i_synd, i_alpha1, i_alpha2, i_abort,
    input  i_fs_tp2, i_fs_tp3, i_fs_tp4, i_fs_tp_valid, i_tp_ready,
    output o_in_ready, o_fs_code, o_fs_synd, o_fs_alpha1, o_fs_alpha2, o_fs_valid,
    output o_tp_valid, o_tp_synd, o_tp_idx, o_tp_last, o_done, o_err
  );

  modport master (
    output i_code, i_start, i_synd, i_alpha1, i_alpha2, i_abort,
    output i_fs_tp2, i_fs_tp3, i_fs_tp4, i_fs_tp_valid, i_tp_ready,
    input  o_in_ready, o_fs_code, o_fs_synd, o_fs_alpha1, o_fs_alpha2, o_fs_valid,
    input  o_tp_valid, o_tp_synd, o_tp_idx, o_tp_last, o_done, o_err
  );

endinterface

// File: rtl/chase_tp_buf.sv
// Four-entry test-pattern syndrome register file.
// Entry 0 (tp1) loads from the codeword syndromes at round start, entries 1..3 (tp2..tp4)
// load together from flip_syndrome. The read port selects by idx_i and zeroes S5..S8 when
// mask_hi_i is set (codes that only use S1..S4).
// Ports: clk_i, rst_i (async, active-high), load_tp1_i/tp1_i, load_flip_i/tp2_i..tp4_i,
//        idx_i, mask_hi_i, tp1_o (raw tp1), tp_synd_o (selected, masked).
module chase_tp_buf
  import chase_tp_scheduler_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    load_tp1_i,
  input  synd_t   tp1_i,
  input  logic    load_flip_i,
  input  synd_t   tp2_i,
  input  synd_t   tp3_i,
  input  synd_t   tp4_i,
  input  tp_idx_t idx_i,
  input  logic    mask_hi_i,
  output synd_t   tp1_o,
  output synd_t   tp_synd_o
);

  synd_t tp_q [4];
  synd_t tp_d [4];
  synd_t sel;

  always_comb begin
    tp_d = tp_q;
    if (load_tp1_i) tp_d[0] = tp1_i;
    if (load_flip_i) begin
      tp_d[1] = tp2_i;
      tp_d[2] = tp3_i;
      tp_d[3] = tp4_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) tp_q[i] <= '0;
    end else begin
      tp_q <= tp_d;
    end
  end

  always_comb begin
    sel = tp_q[0];
    unique case (idx_i)
      TP1: sel = tp_q[0];
      TP2: sel = tp_q[1];
      TP3: sel = tp_q[2];
      TP4: sel = tp_q[3];
    endcase
    if (mask_hi_i) sel[SYN_W-1:LO_W] = '0;
  end

  assign tp1_o     = tp_q[0];
  assign tp_synd_o = sel;

endmodule

// File: rtl/chase_tp_scheduler.sv
// Chase-II test-pattern round sequencer for the BCH decoder.
// Latches a codeword's syndromes and the alpha powers of its two least-reliable positions,
// holds them on the flip_syndrome inputs until tp2..tp4 come back (or a timeout expires),
// then serves tp1..tp4 to the shared key-equation solver over a valid/ready handshake.
// Ports: i_clk, i_rst (async, active-high), bus (chase_tp_scheduler_if.slave).
// Parameters: TIMEOUT = max RUN cycles waiting for flip_syndrome (>= 4),
//             EARLY_EXIT = issue tp1 only when tp1 is already error-free.
module chase_tp_scheduler
  import chase_tp_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 7,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  chase_tp_scheduler_if.slave   bus
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      code_q, code_d;
  alpha_t          a1_q, a1_d;
  alpha_t          a2_q, a2_d;
  tp_idx_t         idx_q, idx_d;
  logic            fs_valid_q, fs_valid_d;
  logic            tp_valid_q, tp_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic  load_tp1, load_flip;
  logic  early, tp_last, hs;
  synd_t tp1_synd, tp_synd;

  chase_tp_buf u_buf (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_tp1_i (load_tp1),
    .tp1_i      (bus.i_synd),
    .load_flip_i(load_flip),
    .tp2_i      (bus.i_fs_tp2),
    .tp3_i      (bus.i_fs_tp3),
    .tp4_i      (bus.i_fs_tp4),
    .idx_i      (idx_q),
    .mask_hi_i  (code_q != CODE_T4),
    .tp1_o      (tp1_synd),
    .tp_synd_o  (tp_synd)
  );

  // Latched data is stable for the whole round, so early/last are pure decodes of registers.
  assign early   = EARLY_EXIT && tp1_is_zero(tp1_synd, code_q);
  assign tp_last = tp_valid_q && (early ? (idx_q == TP1) : (idx_q == TP4));
  assign hs      = tp_valid_q && bus.i_tp_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_tp1  = 1'b0;
    load_flip = 1'b0;

    if (bus.i_abort) begin
      // Abort beats start and handshake; no completion or error is reported.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.i_start && in_ready_q) begin
            load_tp1 = 1'b1;
            code_d   = bus.i_code;
            a1_d     = bus.i_alpha1;
            a2_d     = bus.i_alpha2;
            cnt_d    = '0;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (bus.i_fs_tp_valid) begin
            load_flip = 1'b1;
            idx_d     = TP1;
            state_d   = StIssue;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StIssue: begin
          if (hs) begin
            if (tp_last) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    fs_valid_d = (state_d == StRun);
    tp_valid_d = (state_d == StIssue);
    // Stay not-ready during the done/err pulse so a new start lands the cycle after it.
    in_ready_d = (state_d == StIdle) && !done_d && !err_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      code_q     <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      idx_q      <= TP1;
      fs_valid_q <= 1'b0;
      tp_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      idx_q      <= idx_d;
      fs_valid_q <= fs_valid_d;
      tp_valid_q <= tp_valid_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_in_ready  = in_ready_q;
  assign bus.o_fs_code   = code_q;
  assign bus.o_fs_synd   = tp1_synd;
  assign bus.o_fs_alpha1 = a1_q;
  assign bus.o_fs_alpha2 = a2_q;
  assign bus.o_fs_valid  = fs_valid_q;
  assign bus.o_tp_valid  = tp_valid_q;
  assign bus.o_tp_synd   = tp_synd;
  assign bus.o_tp_idx    = idx_q;
  assign bus.o_tp_last   = tp_last;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_chase_tp_scheduler.sv
// Self-checking bench for chase_tp_scheduler: table of rounds driven through a
// flip_syndrome stub, solver handshakes checked against a queue of expected patterns.
module tb_chase_tp_scheduler;
  import chase_tp_scheduler_pkg::*;

  typedef struct {
    logic [1:0] code;
    synd_t      synd;
    alpha_t     a1;
    alpha_t     a2;
    synd_t      tp2;
    synd_t      tp3;
    synd_t      tp4;
    int         lat;   // RUN cycle on which the stub returns tp2..tp4 (0 = never)
    int         npat;  // patterns the solver must receive
  } round_t;

  typedef struct {
    tp_idx_t idx;
    synd_t   synd;
    logic    last;
  } exp_t;

  localparam synd_t T2 = {4{10'h3C1, 10'h012}};
  localparam synd_t T3 = {4{10'h2B3, 10'h024}};
  localparam synd_t T4 = {4{10'h1A5, 10'h036}};
  localparam alpha_t A1 = {10'h0F1, 10'h0F2, 10'h0F3, 10'h0F4};
  localparam alpha_t A2 = {10'h101, 10'h102, 10'h103, 10'h104};

  logic clk;
  logic rst;
  chase_tp_scheduler_if bus ();

  chase_tp_scheduler #(.TIMEOUT(7), .EARLY_EXIT(1'b1)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  exp_t   exp_q[$];
  int     run_cnt = 0;
  int     stub_lat = 0;
  round_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [SYN_W-1:0] act,
                     input logic [SYN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic synd_t mask_hi(synd_t v, logic [1:0] code);
    synd_t m;
    m = v;
    if (code != 2'b10) m[SYN_W-1:LO_W] = '0;
    return m;
  endfunction

  // One clock: score the handshake about to happen, advance, then update the stub.
  task automatic tick();
    exp_t e;
    if (bus.o_tp_valid && bus.i_tp_ready && !bus.i_abort) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got handshake idx %0d, want none", bus.o_tp_idx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idx", bus.o_tp_idx, e.idx);
        chk("sb_synd", bus.o_tp_synd, e.synd);
        chk("sb_last", bus.o_tp_last, e.last);
      end
    end
    @(posedge clk);
    #1;
    if (bus.o_fs_valid) run_cnt++;
    else run_cnt = 0;
    bus.i_fs_tp_valid = (stub_lat != 0) && bus.o_fs_valid && (run_cnt == stub_lat);
    if (bus.o_done && bus.o_in_ready) begin
      checks++;
      errors++;
      $display("FAIL done_ready_overlap: got done=1 ready=1, want ready=0");
    end
  endtask

  task automatic start_round(input round_t r);
    synd_t vals[4];
    exp_t  e;
    vals = '{r.synd, r.tp2, r.tp3, r.tp4};
    bus.i_code   = r.code;
    bus.i_synd   = r.synd;
    bus.i_alpha1 = r.a1;
    bus.i_alpha2 = r.a2;
    bus.i_fs_tp2 = r.tp2;
    bus.i_fs_tp3 = r.tp3;
    bus.i_fs_tp4 = r.tp4;
    stub_lat     = r.lat;
    for (int k = 0; k < r.npat; k++) begin
      e.idx  = tp_idx_t'(k);
      e.synd = mask_hi(vals[k], r.code);
      e.last = (k == r.npat - 1);
      exp_q.push_back(e);
    end
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("busy_in_ready", bus.o_in_ready, 1'b0);
    chk("run_fs_valid", bus.o_fs_valid, 1'b1);
    chk("run_fs_code", bus.o_fs_code, r.code);
    chk("run_fs_synd", bus.o_fs_synd, r.synd);
    chk("run_fs_alpha1", bus.o_fs_alpha1, r.a1);
    chk("run_fs_alpha2", bus.o_fs_alpha2, r.a2);
  endtask

  // Full round; optionally hold the solver off for hold_cycles at pattern hold_idx.
  task automatic run_round(input round_t r, input int hold_idx, input int hold_cycles);
    int    n;
    int    held;
    logic  seen;
    synd_t snap;
    n = 0;
    held = 0;
    seen = 1'b0;
    snap = '0;
    start_round(r);
    while (!seen && n < 60) begin
      if (hold_idx >= 0 && bus.o_tp_valid && bus.o_tp_idx == tp_idx_t'(hold_idx)
          && held < hold_cycles) begin
        if (held == 0) snap = bus.o_tp_synd;
        else chk("hold_synd_stable", bus.o_tp_synd, snap);
        bus.i_tp_ready = 1'b0;
        bus.i_start    = 1'b1;      // must be ignored while busy
        bus.i_synd     = ~r.synd;   // must not disturb latched data
        held++;
      end else begin
        bus.i_tp_ready = 1'b1;
        bus.i_start    = 1'b0;
      end
      tick();
      n++;
      if (bus.o_done) seen = 1'b1;
    end
    bus.i_start = 1'b0;
    if (hold_idx >= 0) chk("hold_cycles", held, hold_cycles);
    chk("done_seen", seen, 1'b1);
    chk("done_latency", n, r.lat + r.npat + held);
    chk("done_in_ready", bus.o_in_ready, 1'b0);
    chk("sb_drained", exp_q.size(), 0);
    tick();
    chk("done_one_cycle", bus.o_done, 1'b0);
    chk("ready_after_done", bus.o_in_ready, 1'b1);
    exp_q.delete();
  endtask

  initial begin
    int     n;
    round_t r;

    tbl[0] = '{code: 2'b10, synd: {10'h008, 10'h007, 10'h006, 10'h005,
                                   10'h004, 10'h003, 10'h002, 10'h001},
               a1: A1, a2: A2, tp2: T2, tp3: T3, tp4: T4, lat: 4, npat: 4};
    tbl[1] = '{code: 2'b01, synd: {{4{10'h3FF}}, 10'h044, 10'h033, 10'h022, 10'h011},
               a1: A2, a2: A1, tp2: T3, tp3: T4, tp4: T2, lat: 3, npat: 4};
    tbl[2] = '{code: 2'b10, synd: '0, a1: A1, a2: A2, tp2: T2, tp3: T3, tp4: T4,
               lat: 4, npat: 1};
    tbl[3] = '{code: 2'b01, synd: {{4{10'h3FF}}, 40'h0}, a1: A1, a2: A2,
               tp2: T2, tp3: T3, tp4: T4, lat: 3, npat: 1};
    tbl[4] = '{code: 2'b10, synd: {30'h0, 10'h001, 40'h0}, a1: A2, a2: A1,
               tp2: T4, tp3: T2, tp4: T3, lat: 4, npat: 4};
    tbl[5] = '{code: 2'b00, synd: {{4{10'h2AA}}, 10'h004, 30'h0}, a1: A1, a2: A2,
               tp2: T2, tp3: T3, tp4: T4, lat: 3, npat: 4};

    rst = 1'b1;
    bus.i_code = '0;        bus.i_start = 1'b0;     bus.i_synd = '0;
    bus.i_alpha1 = '0;      bus.i_alpha2 = '0;      bus.i_abort = 1'b0;
    bus.i_fs_tp2 = '0;      bus.i_fs_tp3 = '0;      bus.i_fs_tp4 = '0;
    bus.i_fs_tp_valid = 1'b0;  bus.i_tp_ready = 1'b0;
    #22 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_in_ready", bus.o_in_ready, 1'b1);
    chk("rst_fs_valid", bus.o_fs_valid, 1'b0);
    chk("rst_tp_valid", bus.o_tp_valid, 1'b0);
    chk("rst_tp_last", bus.o_tp_last, 1'b0);
    chk("rst_tp_idx", bus.o_tp_idx, 2'd0);
    chk("rst_tp_synd", bus.o_tp_synd, '0);
    chk("rst_fs_code", bus.o_fs_code, 2'd0);
    chk("rst_done", bus.o_done, 1'b0);
    chk("rst_err", bus.o_err, 1'b0);

    // Table of rounds: full t=4, masked t=2, early exits, no-early boundary, code 00
    for (int i = 0; i < 6; i++) run_round(tbl[i], -1, 0);

    // Solver stalls 5 cycles on tp2 (idx 1)
    run_round(tbl[4], 1, 5);

    // Timeout: flip_syndrome never answers
    r = tbl[1];
    r.lat = 0;
    r.npat = 0;
    start_round(r);
    n = 0;
    while (!bus.o_err && n < 20) begin
      tick();
      n++;
    end
    chk("err_seen", bus.o_err, 1'b1);
    chk("err_latency", n, 7);
    chk("err_in_ready", bus.o_in_ready, 1'b0);
    chk("err_no_done", bus.o_done, 1'b0);
    tick();
    chk("err_one_cycle", bus.o_err, 1'b0);
    chk("err_ready_after", bus.o_in_ready, 1'b1);
    chk("err_fs_valid", bus.o_fs_valid, 1'b0);

    // Abort at idx 2 together with start and a pending handshake
    start_round(tbl[0]);
    bus.i_tp_ready = 1'b1;
    n = 0;
    while (!(bus.o_tp_valid && bus.o_tp_idx == TP3) && n < 40) begin
      tick();
      n++;
    end
    chk("abort_at_idx2", bus.o_tp_idx, TP3);
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    chk("abort_tp_valid", bus.o_tp_valid, 1'b0);
    chk("abort_fs_valid", bus.o_fs_valid, 1'b0);
    chk("abort_no_done", bus.o_done, 1'b0);
    chk("abort_no_err", bus.o_err, 1'b0);
    chk("abort_in_ready", bus.o_in_ready, 1'b1);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_quiet_done", bus.o_done, 1'b0);
      chk("abort_start_dropped", bus.o_fs_valid, 1'b0);
    end
    run_round(tbl[1], -1, 0);

    // Asynchronous reset in the middle of RUN
    start_round(tbl[0]);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", bus.o_in_ready, 1'b1);
    chk("arst_fs_valid", bus.o_fs_valid, 1'b0);
    chk("arst_fs_code", bus.o_fs_code, 2'd0);
    chk("arst_fs_synd", bus.o_fs_synd, '0);
    chk("arst_tp_valid", bus.o_tp_valid, 1'b0);
    #3 rst = 1'b0;
    exp_q.delete();
    bus.i_fs_tp_valid = 1'b0;
    run_cnt = 0;
    @(posedge clk);
    #1;
    run_round(tbl[5], -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
